// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid slot: fully registered ready_o,
// 1-cycle latency, flush-to-bubble, and a saturating downstream-stall counter.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [1:0]        occ_o,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // Handshake: a transfer happens on an edge where both valid and ready are 1
  // (input side: valid_i && ready_o, output side: valid_o && ready_i).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                ready_q;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                valid;
  logic                in_fire;
  logic                out_fire;

  assign valid    = (state_q != S_EMPTY);
  assign in_fire  = valid_i && ready_q;
  assign out_fire = valid && ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end else if (in_fire) begin
          skid_data_d = data_i;
          skid_ctrl_d = ctrl_i;
          state_d     = S_TWO;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush drops everything, including a same-cycle accept; payload regs keep
    // their old contents so data_o holds its last value under the bubble.
    if (flush_i) begin
      state_d     = S_EMPTY;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_cnt_i) begin
      stall_cnt_d = '0;
    end else if (valid && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= (state_d != S_TWO);
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = valid;
  assign data_o      = main_data_q;
  assign ctrl_o      = valid ? main_ctrl_q : '0;
  assign occ_o       = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenario tasks plus a negedge scoreboard
// monitor that tracks every accepted entry through to its output transfer.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int NW = 2;
  localparam int W  = DW + CW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_i = '0;
  logic [CW-1:0] ctrl_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [DW-1:0] data_o;
  logic [CW-1:0] ctrl_o;
  logic [1:0]    occ_o;
  logic          clr_cnt_i = 1'b0;
  logic [NW-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [NW-1:0] exp_stall = '0;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .ctrl_i      (ctrl_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .ctrl_o      (ctrl_o),
    .occ_o       (occ_o),
    .clr_cnt_i   (clr_cnt_i),
    .stall_cnt_o (stall_cnt_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic r);
    valid_i = v;
    data_i  = d;
    ctrl_i  = c;
    ready_i = r;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    logic [W-1:0] exp_e;
    if (rst_i) begin
      exp_q.delete();
      exp_stall = '0;
    end else begin
      total++;
      if (occ_o !== 2'(exp_q.size())) begin
        bad++;
        $display("FAIL sb_occ: occ_o=%0d expected=%0d", occ_o, exp_q.size());
      end
      total++;
      if (ready_o !== (exp_q.size() != 2)) begin
        bad++;
        $display("FAIL sb_ready: ready_o=%0b expected=%0b", ready_o, exp_q.size() != 2);
      end
      total++;
      if (stall_cnt_o !== exp_stall) begin
        bad++;
        $display("FAIL sb_stall: stall_cnt_o=%0d expected=%0d", stall_cnt_o, exp_stall);
      end
      if (!valid_o) begin
        total++;
        if (ctrl_o !== '0) begin
          bad++;
          $display("FAIL sb_bubble_ctrl: ctrl_o=%h expected=0", ctrl_o);
        end
      end
      if (valid_o && ready_i) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got data=%h ctrl=%h with empty queue", data_o, ctrl_o);
        end else begin
          exp_e = exp_q.pop_front();
          if ({ctrl_o, data_o} !== exp_e) begin
            bad++;
            $display("FAIL sb_data: got ctrl=%h data=%h expected ctrl=%h data=%h",
                     ctrl_o, data_o, exp_e[W-1:DW], exp_e[DW-1:0]);
          end
        end
      end
      if (flush_i) exp_q.delete();
      else if (valid_i && ready_o) exp_q.push_back({ctrl_i, data_i});
      if (clr_cnt_i) exp_stall = '0;
      else if (valid_o && !ready_i && exp_stall != 2'd3) exp_stall = exp_stall + 2'd1;
    end
  end

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b1; clr_cnt_i = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);
    step();
    step();
    rst_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    total++;
    if ({valid_o, data_o, ctrl_o, ready_o, occ_o, stall_cnt_o} !== {1'b0, 32'h0, 4'h0, 1'b1, 2'd0, 2'd0}) begin
      bad++;
      $display("FAIL reset_vals: valid=%0b data=%h ctrl=%h ready=%0b occ=%0d cnt=%0d expected 0,0,0,1,0,0",
               valid_o, data_o, ctrl_o, ready_o, occ_o, stall_cnt_o);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h10 + i, 4'(i + 1), 1'b1);
      step();
      total++;
      if ({valid_o, data_o, occ_o, stall_cnt_o} !== {1'b1, 32'h10 + i, 2'd1, 2'd0}) begin
        bad++;
        $display("FAIL stream_%0d: valid=%0b data=%h occ=%0d cnt=%0d expected 1,%h,1,0",
                 i, valid_o, data_o, occ_o, stall_cnt_o, 32'h10 + i);
      end
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    total++;
    if ({valid_o, occ_o} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL stream_drain: valid=%0b occ=%0d expected 0,0", valid_o, occ_o);
    end
  endtask

  task automatic test_skid();
    drive(1'b1, 32'hA, 4'h3, 1'b0);
    step();
    drive(1'b1, 32'hB, 4'h5, 1'b0);
    step();
    total++;
    if ({occ_o, ready_o, data_o} !== {2'd2, 1'b0, 32'hA}) begin
      bad++;
      $display("FAIL skid_fill: occ=%0d ready=%0b data=%h expected 2,0,a", occ_o, ready_o, data_o);
    end
    drive(1'b1, 32'hEE, 4'h7, 1'b1);
    step();
    total++;
    if ({occ_o, data_o, ready_o} !== {2'd1, 32'hB, 1'b1}) begin
      bad++;
      $display("FAIL skid_out_a: occ=%0d data=%h ready=%0b expected 1,b,1", occ_o, data_o, ready_o);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
    total++;
    if ({occ_o, valid_o} !== {2'd0, 1'b0}) begin
      bad++;
      $display("FAIL skid_out_b: occ=%0d valid=%0b expected 0,0", occ_o, valid_o);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h21, 4'h1, 1'b0);
    step();
    drive(1'b1, 32'h22, 4'h2, 1'b0);
    step();
    flush_i = 1'b1;
    drive(1'b1, 32'hC, 4'hF, 1'b0);
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    total++;
    if ({valid_o, ctrl_o, occ_o, ready_o} !== {1'b0, 4'h0, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL flush_two: valid=%0b ctrl=%h occ=%0d ready=%0b expected 0,0,0,1",
               valid_o, ctrl_o, occ_o, ready_o);
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (valid_o !== 1'b0 || data_o === 32'hC) begin
        bad++;
        $display("FAIL flush_leak_%0d: valid=%0b data=%h expected valid 0 and no 0xc", i, valid_o, data_o);
      end
    end
    drive(1'b1, 32'h23, 4'h4, 1'b0);
    step();
    flush_i = 1'b1;
    drive(1'b1, 32'hD, 4'h6, 1'b0);
    step();
    flush_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    total++;
    if ({valid_o, occ_o, data_o} !== {1'b0, 2'd0, 32'h23}) begin
      bad++;
      $display("FAIL flush_one: valid=%0b occ=%0d data=%h expected 0,0,23", valid_o, occ_o, data_o);
    end
  endtask

  task automatic test_saturation();
    logic [NW-1:0] want;
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    total++;
    if (stall_cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL sat_clr0: cnt=%0d expected 0", stall_cnt_o);
    end
    drive(1'b1, 32'h30, 4'h9, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      want = (i < 3) ? NW'(i + 1) : 2'd3;
      total++;
      if (stall_cnt_o !== want) begin
        bad++;
        $display("FAIL sat_cnt_%0d: cnt=%0d expected %0d", i, stall_cnt_o, want);
      end
    end
    clr_cnt_i = 1'b1;
    step();
    clr_cnt_i = 1'b0;
    total++;
    if (stall_cnt_o !== 2'd0) begin
      bad++;
      $display("FAIL sat_clr: cnt=%0d expected 0", stall_cnt_o);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++;
    if ({stall_cnt_o, occ_o} !== {2'd1, 2'd0}) begin
      bad++;
      $display("FAIL sat_flush: cnt=%0d occ=%0d expected 1,0", stall_cnt_o, occ_o);
    end
  endtask

  task automatic test_reset_mid_two();
    drive(1'b1, 32'h41, 4'h1, 1'b0);
    step();
    drive(1'b1, 32'h42, 4'h2, 1'b0);
    step();
    rst_i = 1'b1; clr_cnt_i = 1'b0;
    drive(1'b1, 32'h99, 4'hF, 1'b1);
    step();
    rst_i = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    total++;
    if ({valid_o, data_o, ctrl_o, ready_o, occ_o, stall_cnt_o} !== {1'b0, 32'h0, 4'h0, 1'b1, 2'd0, 2'd0}) begin
      bad++;
      $display("FAIL rst_two: valid=%0b data=%h ctrl=%h ready=%0b occ=%0d cnt=%0d expected 0,0,0,1,0,0",
               valid_o, data_o, ctrl_o, ready_o, occ_o, stall_cnt_o);
    end
    drive(1'b1, 32'h55, 4'hA, 1'b1);
    step();
    total++;
    if ({valid_o, data_o, ctrl_o, occ_o} !== {1'b1, 32'h55, 4'hA, 2'd1}) begin
      bad++;
      $display("FAIL rst_first: valid=%0b data=%h ctrl=%h occ=%0d expected 1,55,a,1",
               valid_o, data_o, ctrl_o, occ_o);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
  endtask

  task automatic test_bubble();
    drive(1'b0, 32'h77, 4'hF, 1'b0);
    step();
    total++;
    if ({ctrl_o, valid_o} !== {4'h0, 1'b0}) begin
      bad++;
      $display("FAIL bubble: ctrl=%h valid=%0b expected 0,0", ctrl_o, valid_o);
    end
    drive(1'b1, 32'h66, 4'hF, 1'b0);
    step();
    total++;
    if ({ctrl_o, valid_o} !== {4'hF, 1'b1}) begin
      bad++;
      $display("FAIL bubble_valid: ctrl=%h valid=%0b expected f,1", ctrl_o, valid_o);
    end
    drive(1'b0, '0, '0, 1'b1);
    step();
  endtask

  task automatic test_random();
    int budget;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
      flush_i   = ($urandom_range(0, 39) == 0);
      clr_cnt_i = ($urandom_range(0, 29) == 0);
      step();
    end
    flush_i = 1'b0; clr_cnt_i = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    budget = 0;
    while (occ_o != 2'd0 && budget < 10) begin
      step();
      budget++;
    end
    step();
    total++;
    if (occ_o !== 2'd0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: occ=%0d queue=%0d expected 0,0", occ_o, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_saturation();
    test_reset_mid_two();
    test_bubble();
    test_random();
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, setting the payload width (ALU result, store data, RD and similar fields packed by the instantiator).
REQ-002 The block SHALL have parameter CTRL_W, default 4, setting the control-bit width (MemtoReg, MemWrite, MemRead, RegWrite).
REQ-003 The block SHALL have parameter CNT_W, default 8, setting the stall-counter width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: synchronous flush (bubble insertion).
REQ-007 The block SHALL have port valid_i, input, 1 bit: upstream entry valid.
REQ-008 The block SHALL have port ready_o, output, 1 bit: stage can accept an entry; driven directly from a register.
REQ-009 The block SHALL have port data_i, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port ctrl_i, input, CTRL_W bits: upstream control bits.
REQ-011 The block SHALL have port valid_o, output, 1 bit: downstream entry valid.
REQ-012 The block SHALL have port ready_i, input, 1 bit: downstream accepts.
REQ-013 The block SHALL have port data_o, output, DATA_W bits: downstream payload.
REQ-014 The block SHALL have port ctrl_o, output, CTRL_W bits: downstream control bits.
REQ-015 The block SHALL have port occ_o, output, 2 bits: occupancy, 0 to 2.
REQ-016 The block SHALL have port clr_cnt_i, input, 1 bit: synchronous clear of the stall counter.
REQ-017 The block SHALL have port stall_cnt_o, output, CNT_W bits: saturating count of downstream-stall cycles.

Function
REQ-018 Handshake definitions SHALL be:
- Input fire = valid_i && ready_o.
- Output fire = valid_o && ready_i.
REQ-019 The block SHALL hold two entries:
- MAIN, which drives the outputs.
- SKID, which holds overflow.
- The state machine SHALL have states EMPTY (occ 0), ONE (occ 1) and TWO (occ 2).
REQ-020 State EMPTY transitions SHALL be:
- Input fire: load MAIN, go to ONE.
- Otherwise: stay in EMPTY.
REQ-021 State ONE transitions SHALL be:
- Input fire with output fire: MAIN reloads from the input, stay in ONE.
- Output fire only: go to EMPTY.
- Input fire only: load SKID, go to TWO.
- Neither: hold.
REQ-022 State TWO transitions SHALL be:
- ready_o = 0 in this state.
- Output fire: MAIN takes SKID, go to ONE.
- Otherwise: hold.
- valid_i SHALL be ignored in TWO.
REQ-023 The registered ready_o SHALL equal 1 in EMPTY and ONE, and 0 in TWO, one cycle after the state is entered; no combinational path SHALL exist from ready_i to ready_o.
REQ-024 Latency SHALL be 1 cycle: an entry accepted at edge n is visible on data_o/valid_o after edge n; sustained throughput SHALL be 1 entry per cycle while ready_i = 1.
REQ-025 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-026 When valid_o = 0, ctrl_o SHALL be forced to all-zero (bubble); data_o SHALL hold its last value.
REQ-027 When flush_i = 1, the next state SHALL be EMPTY:
- Both entries are discarded.
- An input fire in the same cycle is discarded.
- ready_o = 1 on the next cycle.
- flush_i SHALL take priority over all handshake events.
REQ-028 stall_cnt_o SHALL:
- Increment by 1 on each cycle with valid_o && !ready_i.
- Saturate at 2^CNT_W-1 with no wrap.
- Clear to 0 on clr_cnt_i, which takes priority over increment.
- Remain unaffected by flush_i.
REQ-029 occ_o SHALL reflect the current state: EMPTY = 0, ONE = 1, TWO = 2.

Reset
REQ-030 With rst_i = 1 at an edge, the block SHALL load:
- state EMPTY
- valid_o = 0
- data_o = 0
- ctrl_o = 0
- ready_o = 1
- occ_o = 0
- stall_cnt_o = 0
- SKID contents = 0
REQ-031 rst_i SHALL take priority over flush_i, clr_cnt_i and all handshakes; inputs in the reset cycle SHALL be ignored.
REQ-032 Reset asserted mid-operation (state TWO) SHALL discard both entries in one cycle.

Verification
REQ-033 Streaming: ready_i = 1, valid_i = 1, data 0x10..0x14 on consecutive cycles -> data_o shows 0x10..0x14 one cycle later, back-to-back; occ_o stays 1; stall_cnt_o stays 0.
REQ-034 Skid fill: state ONE holding 0xA, ready_i = 0, input 0xB -> occ_o = 2, ready_o = 0 next cycle; then ready_i = 1 for 2 cycles -> outputs 0xA then 0xB, occ_o goes 1 then 0.
REQ-035 Flush in TWO: flush_i = 1 with valid_i = 1, data 0xC -> next cycle valid_o = 0, ctrl_o = 0, occ_o = 0, ready_o = 1; 0xC never appears.
REQ-036 Saturation with CNT_W = 2: hold valid_o = 1 with ready_i = 0 for 6 cycles -> stall_cnt_o reads 1, 2, 3, 3, 3, 3; clr_cnt_i = 1 -> 0.
REQ-037 Reset mid-TWO: rst_i = 1 for 1 cycle -> all outputs at the REQ-030 values; the first accepted entry after reset, 0x55, appears 1 cycle later.
REQ-038 Bubble: ctrl_i = 4'b1111 with valid_i = 0 -> ctrl_o = 0, valid_o = 0.
